// File: rtl/bcd_seq_pkg.sv
// Shared definitions for the BCD sequencer slice: FSM state encoding,
// digit width and the excess-3 conversion constants.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  XS3_OFFSET = 4'd3;
  localparam logic [3:0]  ERR_CODE   = 4'hF;  // never produced by a legal digit
  localparam logic [3:0]  MAX_DIGIT  = 4'd9;

endpackage : bcd_seq_pkg

// File: rtl/bcd_digit_xlat.sv
// Combinational single-digit 8421 -> excess-3 converter, shared by all
// digit positions of the sequencer.
//
// Optional feature macro: BCD_SEQ_ERR_CHECK_EN
//   defined   : digits 10..15 produce code ERR_CODE and err=1
//   undefined : no range check, code = (digit + 3) mod 16, err=0
//
// Ports:
//   digit  in   4  BCD digit
//   code   out  4  excess-3 code
//   err    out  1  digit out of range (only with BCD_SEQ_ERR_CHECK_EN)
module bcd_digit_xlat
  import bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] code,
  output logic               err
);

  always_comb begin
    // NOTE: every output gets a default at the top of a combinational block,
    // so no path leaves it unassigned and no latch is inferred.
    code = digit + XS3_OFFSET;  // 4-bit add, wraps for 13..15
    err  = 1'b0;
`ifdef BCD_SEQ_ERR_CHECK_EN
    if (digit > MAX_DIGIT) begin
      code = ERR_CODE;
      err  = 1'b1;
    end
`endif
  end

endmodule : bcd_digit_xlat

// File: rtl/bcd_convert_sequencer.sv
// Converts a packed multi-digit BCD word to excess-3 by time-sharing one
// digit converter, one digit per clock, least-significant digit first.
// Upstream and downstream use valid/ready handshakes.
//
// Optional feature macro: BCD_SEQ_ERR_CHECK_EN (range check in bcd_digit_xlat)
//
// Ports:
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   in_valid   in   1           upstream word valid
//   in_ready   out  1           block can accept a word (IDLE)
//   in_bcd     in   4*DIGITS    packed BCD word, digit 0 in [3:0]
//   out_valid  out  1           converted word valid (DONE)
//   out_ready  in   1           downstream accepts word
//   out_code   out  4*DIGITS    excess-3 word, digit i in [4i+3:4i]
//   out_err    out  DIGITS      per-digit invalid-input flag
//   busy       out  1           high in CONV or DONE
module bcd_convert_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGIT_W*DIGITS-1:0]   in_bcd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DIGIT_W*DIGITS-1:0]   out_code,
  output logic [DIGITS-1:0]           out_err,
  output logic                        busy
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [DIGIT_W*DIGITS-1:0]   in_reg;
  logic [DIGIT_W-1:0]          cur_digit;
  logic [DIGIT_W-1:0]          cur_code;
  logic                        cur_err;

  // Handshake/status outputs decode the state register only, so neither
  // in_valid nor out_ready reaches them combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CONV) || (state == DONE);

  assign cur_digit = in_reg[DIGIT_W*int'(idx) +: DIGIT_W];

  bcd_digit_xlat u_xlat (
    .digit (cur_digit),
    .code  (cur_code),
    .err   (cur_err)
  );

  // NOTE: the captured word is a handful of flops, not a RAM, so it is reset
  // along with everything else; a reset mid-word then leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      in_reg   <= '0;
      out_code <= '0;
      out_err  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg  <= in_bcd;
            idx     <= '0;
            out_err <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          out_code[DIGIT_W*int'(idx) +: DIGIT_W] <= cur_code;
          out_err[idx]                           <= cur_err;
          idx                                    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : bcd_convert_sequencer
